// File: rtl/emmc_ddr8_data_tx_if.sv
// ---------------------------------------------------------------------------
// emmc_ddr8_data_tx_if
//   Bundles the write-data handshake and the DAT-bus outputs of the eMMC
//   8-bit DDR transmit framer.
//
//   in_data  [15:0] : payload word, [7:0] rising-edge byte, [15:8] falling
//   in_valid        : in_data holds a valid word
//   in_ready        : framer can accept a word this cycle
//   d1_wire  [7:0]  : DAT lanes for the rising card-clock edge
//   d2_wire  [7:0]  : DAT lanes for the falling card-clock edge
//   dat_oe          : DAT tristate enable
//   clk_stop        : request to hold the card clock (payload underrun)
//
//   master : the side that supplies payload and consumes the bus values
//   slave  : the framer itself
// ---------------------------------------------------------------------------
interface emmc_ddr8_data_tx_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  d1_wire;
  logic [7:0]  d2_wire;
  logic        dat_oe;
  logic        clk_stop;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  d1_wire,
    input  d2_wire,
    input  dat_oe,
    input  clk_stop
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output d1_wire,
    output d2_wire,
    output dat_oe,
    output clk_stop
  );
endinterface

// File: rtl/emmc_ddr8_data_tx.sv
// ---------------------------------------------------------------------------
// emmc_ddr8_data_tx
//   Transmit-side data block framer for eMMC 8-bit DDR write mode. Each block
//   goes out as: start bit on all lanes, BLOCK_BYTES/2 payload words (two
//   bytes per card clock), a 16-bit CRC per lane and per clock edge, then the
//   end bit. The lane values are registered and feed the DDR output stage.
//
//   Ports
//     clock    : controller clock, one card-clock period per cycle
//     reset_n  : synchronous active-low reset
//     start    : one-cycle request to send a block, honoured only when idle
//     bus      : slave side of emmc_ddr8_data_tx_if (handshake + DAT values)
//     busy     : a block is in progress
//     done     : one-cycle pulse after the end bit has been driven
// ---------------------------------------------------------------------------
module emmc_ddr8_data_tx #(
  parameter int BLOCK_BYTES = 512
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  emmc_ddr8_data_tx_if.slave        bus,
  output logic                      busy,
  output logic                      done
);

  localparam int WORDS = BLOCK_BYTES / 2;
  // One counter walks both the payload words and the 16 CRC bit times, so it
  // must be wide enough for whichever of the two is longer.
  localparam int CW = (WORDS > 16) ? $clog2(WORDS) : 4;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
  localparam logic [CW-1:0] LAST_CRC  = CW'(15);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_CRC   = 3'd3,
    S_END   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [7:0][15:0] crcRise_q;
  logic [7:0][15:0] crcFall_q;
  logic [7:0]       d1_q;
  logic [7:0]       d2_q;
  logic             datOe_q;
  logic             clkStop_q;
  logic             done_q;
  logic             transfer;

  // Serial CRC16-CCITT step (x^16 + x^12 + x^5 + 1), one data bit per call.
  function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[15];
    crcStep = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign transfer = (state_q == S_DATA) && bus.in_valid;

  // The bus registers are loaded with the values that belong to the state
  // being left, so lane values trail the state register by one cycle.
  // dat_oe still high while idle can only mean the end bit is on the wire
  // right now, which is exactly when the following cycle must pulse done.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      crcRise_q <= '0;
      crcFall_q <= '0;
      d1_q      <= 8'hFF;
      d2_q      <= 8'hFF;
      datOe_q   <= 1'b0;
      clkStop_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= (state_q == S_IDLE) && datOe_q;
      clkStop_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          d1_q    <= 8'hFF;
          d2_q    <= 8'hFF;
          datOe_q <= 1'b0;
          if (start) begin
            state_q   <= S_START;
            cnt_q     <= '0;
            crcRise_q <= '0;
            crcFall_q <= '0;
          end
        end
        S_START: begin
          d1_q    <= 8'h00;
          d2_q    <= 8'h00;
          datOe_q <= 1'b1;
          state_q <= S_DATA;
        end
        S_DATA: begin
          if (transfer) begin
            d1_q <= bus.in_data[7:0];
            d2_q <= bus.in_data[15:8];
            for (int i = 0; i < 8; i++) begin
              crcRise_q[i] <= crcStep(crcRise_q[i], bus.in_data[i]);
              crcFall_q[i] <= crcStep(crcFall_q[i], bus.in_data[8+i]);
            end
            if (cnt_q == LAST_WORD) begin
              cnt_q   <= '0;
              state_q <= S_CRC;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            // Underrun: hold the lanes and ask for the card clock to pause.
            clkStop_q <= 1'b1;
          end
        end
        S_CRC: begin
          for (int i = 0; i < 8; i++) begin
            d1_q[i]      <= crcRise_q[i][15];
            d2_q[i]      <= crcFall_q[i][15];
            crcRise_q[i] <= {crcRise_q[i][14:0], 1'b0};
            crcFall_q[i] <= {crcFall_q[i][14:0], 1'b0};
          end
          if (cnt_q == LAST_CRC) begin
            cnt_q   <= '0;
            state_q <= S_END;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_END: begin
          d1_q    <= 8'hFF;
          d2_q    <= 8'hFF;
          datOe_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = (state_q == S_DATA);
  assign bus.d1_wire  = d1_q;
  assign bus.d2_wire  = d2_q;
  assign bus.dat_oe   = datOe_q;
  assign bus.clk_stop = clkStop_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_emmc_ddr8_data_tx.sv
// ---------------------------------------------------------------------------
// tb_emmc_ddr8_data_tx
//   Directed bench for emmc_ddr8_data_tx. A 2-byte instance covers the
//   single-word frame cycle by cycle; a 512-byte instance covers full blocks,
//   underrun, reset mid-block, ignored starts and back-to-back blocks.
// ---------------------------------------------------------------------------
module tb_emmc_ddr8_data_tx;

  logic clock;
  logic resetN;
  logic startB, busyB, doneB;
  logic startS, busyS, doneS;

  emmc_ddr8_data_tx_if ifB ();
  emmc_ddr8_data_tx_if ifS ();

  emmc_ddr8_data_tx #(.BLOCK_BYTES(512)) dutBig (
    .clock(clock), .reset_n(resetN), .start(startB), .bus(ifB), .busy(busyB), .done(doneB)
  );

  emmc_ddr8_data_tx #(.BLOCK_BYTES(2)) dutSmall (
    .clock(clock), .reset_n(resetN), .start(startS), .bus(ifS), .busy(busyS), .done(doneS)
  );

  int vectors;
  int miscompares;

  logic [15:0] payload [256];
  logic [15:0] capQ [$];
  int oeCycles, stopCycles, holdErr, strayStop, doneCount, doneOeErr;
  logic [7:0] lastD1, lastD2;

  int          obsLen;
  logic [15:0] obsFirst, obsLast;
  logic [15:0] obsCrcR [8];
  logic [15:0] obsCrcF [8];
  logic [15:0] obsWords [$];

  // Free-running clock, 10 time units per card-clock period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Bus monitor on the large instance: records every enabled cycle that is
  // not a clock-stop cycle, and tallies stalls, hold errors and done pulses.
  initial begin
    forever begin
      @(negedge clock);
      if (ifB.dat_oe === 1'b1) begin
        oeCycles++;
        if (ifB.clk_stop === 1'b1) begin
          stopCycles++;
          if (ifB.d1_wire !== lastD1 || ifB.d2_wire !== lastD2) holdErr++;
        end else begin
          capQ.push_back({ifB.d2_wire, ifB.d1_wire});
        end
        lastD1 = ifB.d1_wire;
        lastD2 = ifB.d2_wire;
      end else if (ifB.clk_stop !== 1'b0) begin
        strayStop++;
      end
      if (doneB === 1'b1) begin
        doneCount++;
        if (ifB.dat_oe !== 1'b0) doneOeErr++;
      end
    end
  end

  // Reference CRC16-CCITT of one de-interleaved lane stream. Bit position
  // 0..7 is a rising-edge lane, 8..15 the matching falling-edge lane.
  function automatic logic [15:0] refCrc(input int bitPos);
    logic [15:0] c;
    c = 16'h0000;
    for (int w = 0; w < 256; w++) begin
      if (payload[w][bitPos] ^ c[15]) c = (c << 1) ^ 16'h1021;
      else c = c << 1;
    end
    return c;
  endfunction

  task automatic fillPattern(input logic [15:0] seed);
    for (int w = 0; w < 256; w++) payload[w] = 16'(w * 16'h0137) ^ seed;
  endtask

  // Splits the captured stream into start marker, payload, CRC bits per
  // lane and end marker.
  task automatic collectBlock();
    int n;
    n = capQ.size();
    obsLen = n;
    obsWords.delete();
    obsFirst = 'x;
    obsLast  = 'x;
    for (int i = 0; i < 8; i++) begin
      obsCrcR[i] = 'x;
      obsCrcF[i] = 'x;
    end
    if (n >= 18) begin
      obsFirst = capQ[0];
      obsLast  = capQ[n-1];
      for (int w = 1; w < n - 17; w++) obsWords.push_back(capQ[w]);
      for (int c = 0; c < 16; c++) begin
        for (int i = 0; i < 8; i++) begin
          obsCrcR[i][15-c] = capQ[n-17+c][i];
          obsCrcF[i][15-c] = capQ[n-17+c][8+i];
        end
      end
    end
  endtask

  // Drives one block into the large instance. Entered and left on a falling
  // edge. Counting from the falling edge that commits the last word, edges
  // 1..16 fall in CRC cycles 0..15 and edge 17 falls in END.
  task automatic applyStimulus(input int stallAt, input int stallLen, input int startAtWord,
                               input bit startInEnd, input int resetAtCrc, input bit chain,
                               input bit skipStart, output bit timedOut);
    int wordIdx;
    int stallLeft;
    int sinceLast;
    wordIdx = 0;
    stallLeft = stallLen;
    sinceLast = -1;
    timedOut = 1'b1;
    capQ.delete();
    oeCycles = 0; stopCycles = 0; holdErr = 0; strayStop = 0; doneCount = 0; doneOeErr = 0;
    if (!skipStart) begin
      startB = 1'b1;
      @(negedge clock);
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      startB = 1'b0;
      if (doneB === 1'b1) begin
        timedOut = 1'b0;
        if (chain) startB = 1'b1;
        break;
      end
      if (sinceLast >= 0) sinceLast++;
      if (startInEnd && sinceLast == 17) startB = 1'b1;
      if (resetAtCrc >= 0 && sinceLast == resetAtCrc + 1) begin
        resetN = 1'b0;
        timedOut = 1'b0;
        break;
      end
      if (wordIdx == startAtWord && ifB.in_ready === 1'b1) startB = 1'b1;
      if (wordIdx == stallAt && stallLeft > 0) begin
        ifB.in_valid = 1'b0;
        stallLeft--;
      end else if (wordIdx < 256) begin
        ifB.in_valid = 1'b1;
        ifB.in_data  = payload[wordIdx];
      end else begin
        ifB.in_valid = 1'b0;
      end
      if (ifB.in_valid && ifB.in_ready === 1'b1) begin
        wordIdx++;
        if (wordIdx == 256) sinceLast = 0;
      end
      @(negedge clock);
    end
    ifB.in_valid = 1'b0;
    if (resetAtCrc < 0 || timedOut) @(negedge clock);
    startB = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    startB = 1'b1;
    startS = 1'b1;
    ifB.in_valid = 1'b1;
    ifS.in_valid = 1'b1;
    repeat (3) @(negedge clock);
    vectors++; if ({ifB.d1_wire, ifB.d2_wire} !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL reset_d1d2 got %h expected ffff", {ifB.d1_wire, ifB.d2_wire}); end
    vectors++; if (ifB.dat_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dat_oe got %b expected 0", ifB.dat_oe); end
    vectors++; if (ifB.clk_stop !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_clk_stop got %b expected 0", ifB.clk_stop); end
    vectors++; if (busyB !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b expected 0", busyB); end
    vectors++; if (doneB !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b expected 0", doneB); end
    vectors++; if (ifB.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b expected 0", ifB.in_ready); end
    vectors++; if ({ifS.d1_wire, ifS.d2_wire, ifS.dat_oe, busyS} !== 18'h3FFFC) begin miscompares++; $display("[TB] FAIL reset_small got %h expected 3fffc", {ifS.d1_wire, ifS.d2_wire, ifS.dat_oe, busyS}); end
    startB = 1'b0;
    startS = 1'b0;
    ifB.in_valid = 1'b0;
    ifS.in_valid = 1'b0;
    resetN = 1'b1;
    repeat (2) @(negedge clock);
    vectors++; if (busyB !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_release_busy got %b expected 0", busyB); end
  endtask

  // BLOCK_BYTES=2, word 0x0001: lane 0 rising CRC is 0x1021, all else 0.
  task automatic test_single_word();
    logic [15:0] crcL0;
    logic [7:0]  expD1, expD2;
    logic        expOe, expDone, expBusy;
    crcL0 = 16'h1021;
    startS = 1'b1;
    @(negedge clock);
    startS = 1'b0;
    ifS.in_data  = 16'h0001;
    ifS.in_valid = 1'b1;
    for (int s = 1; s <= 22; s++) begin
      expD2 = 8'h00;
      expOe = 1'b1;
      expDone = (s == 21);
      expBusy = (s <= 19);
      if (s == 1)       begin expD1 = 8'hFF; expD2 = 8'hFF; expOe = 1'b0; end
      else if (s == 2)  expD1 = 8'h00;
      else if (s == 3)  expD1 = 8'h01;
      else if (s <= 19) expD1 = {7'b0, crcL0[19-s]};
      else if (s == 20) begin expD1 = 8'hFF; expD2 = 8'hFF; end
      else              begin expD1 = 8'hFF; expD2 = 8'hFF; expOe = 1'b0; end
      vectors++;
      if ({ifS.d1_wire, ifS.d2_wire, ifS.dat_oe, doneS, busyS} !== {expD1, expD2, expOe, expDone, expBusy}) begin
        miscompares++;
        $display("[TB] FAIL single_word_step%0d got d1=%h d2=%h oe=%b done=%b busy=%b expected d1=%h d2=%h oe=%b done=%b busy=%b",
                 s, ifS.d1_wire, ifS.d2_wire, ifS.dat_oe, doneS, busyS, expD1, expD2, expOe, expDone, expBusy);
      end
      if (s == 3) ifS.in_valid = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic test_zero_payload();
    bit to;
    for (int w = 0; w < 256; w++) payload[w] = 16'h0000;
    applyStimulus(-1, 0, -1, 1'b0, -1, 1'b0, 1'b0, to);
    collectBlock();
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL zero_timeout got timeout expected done"); end
    vectors++; if (oeCycles !== 274) begin miscompares++; $display("[TB] FAIL zero_oe_cycles got %0d expected 274", oeCycles); end
    vectors++; if (doneCount !== 1) begin miscompares++; $display("[TB] FAIL zero_done_count got %0d expected 1", doneCount); end
    vectors++; if (stopCycles + strayStop !== 0) begin miscompares++; $display("[TB] FAIL zero_clk_stop got %0d expected 0", stopCycles + strayStop); end
    vectors++; if (doneOeErr !== 0) begin miscompares++; $display("[TB] FAIL zero_done_oe got %0d expected 0", doneOeErr); end
    vectors++; if (obsFirst !== 16'h0000 || obsLast !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL zero_markers got %h/%h expected 0000/ffff", obsFirst, obsLast); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (obsCrcR[i] !== 16'h0000 || obsCrcF[i] !== 16'h0000) begin miscompares++; $display("[TB] FAIL zero_crc_lane%0d got %h/%h expected 0000/0000", i, obsCrcR[i], obsCrcF[i]); end
    end
  endtask

  task automatic test_underrun();
    bit to;
    fillPattern(16'hA5C3);
    applyStimulus(100, 3, -1, 1'b0, -1, 1'b0, 1'b0, to);
    collectBlock();
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL underrun_timeout got timeout expected done"); end
    vectors++; if (oeCycles !== 277) begin miscompares++; $display("[TB] FAIL underrun_oe_cycles got %0d expected 277", oeCycles); end
    vectors++; if (stopCycles !== 3 || strayStop !== 0) begin miscompares++; $display("[TB] FAIL underrun_clk_stop got %0d/%0d expected 3/0", stopCycles, strayStop); end
    vectors++; if (holdErr !== 0) begin miscompares++; $display("[TB] FAIL underrun_hold got %0d expected 0", holdErr); end
    vectors++; if (doneCount !== 1) begin miscompares++; $display("[TB] FAIL underrun_done_count got %0d expected 1", doneCount); end
    vectors++; if (obsLen !== 274) begin miscompares++; $display("[TB] FAIL underrun_frame_len got %0d expected 274", obsLen); end
    for (int w = 0; w < 256; w++) begin
      vectors++; if (w >= obsWords.size() || obsWords[w] !== payload[w]) begin miscompares++; $display("[TB] FAIL underrun_word%0d got %h expected %h", w, (w < obsWords.size()) ? obsWords[w] : 16'hxxxx, payload[w]); end
    end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (obsCrcR[i] !== refCrc(i)) begin miscompares++; $display("[TB] FAIL underrun_crc_rise%0d got %h expected %h", i, obsCrcR[i], refCrc(i)); end
      vectors++; if (obsCrcF[i] !== refCrc(8+i)) begin miscompares++; $display("[TB] FAIL underrun_crc_fall%0d got %h expected %h", i, obsCrcF[i], refCrc(8+i)); end
    end
  endtask

  task automatic test_reset_mid_block();
    bit to;
    fillPattern(16'h3C96);
    applyStimulus(-1, 0, -1, 1'b0, 5, 1'b0, 1'b0, to);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL midreset_reach_crc got timeout expected crc cycle 5"); end
    @(negedge clock);
    vectors++; if ({ifB.d1_wire, ifB.d2_wire} !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL midreset_d1d2 got %h expected ffff", {ifB.d1_wire, ifB.d2_wire}); end
    vectors++; if ({ifB.dat_oe, ifB.clk_stop, busyB, doneB, ifB.in_ready} !== 5'b0) begin miscompares++; $display("[TB] FAIL midreset_ctrl got %b expected 00000", {ifB.dat_oe, ifB.clk_stop, busyB, doneB, ifB.in_ready}); end
    resetN = 1'b1;
    repeat (5) @(negedge clock);
    vectors++; if (doneCount !== 0) begin miscompares++; $display("[TB] FAIL midreset_no_done got %0d expected 0", doneCount); end
    applyStimulus(-1, 0, -1, 1'b0, -1, 1'b0, 1'b0, to);
    collectBlock();
    vectors++; if (to || oeCycles !== 274 || doneCount !== 1) begin miscompares++; $display("[TB] FAIL midreset_next_block got to=%b oe=%0d done=%0d expected 0/274/1", to, oeCycles, doneCount); end
    vectors++; if (obsFirst !== 16'h0000 || obsLast !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL midreset_markers got %h/%h expected 0000/ffff", obsFirst, obsLast); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (obsCrcR[i] !== refCrc(i) || obsCrcF[i] !== refCrc(8+i)) begin miscompares++; $display("[TB] FAIL midreset_crc_lane%0d got %h/%h expected %h/%h", i, obsCrcR[i], obsCrcF[i], refCrc(i), refCrc(8+i)); end
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    fillPattern(16'h5A0F);
    applyStimulus(-1, 0, 50, 1'b1, -1, 1'b0, 1'b0, to);
    collectBlock();
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL ignore_timeout got timeout expected done"); end
    vectors++; if (oeCycles !== 274 || obsLen !== 274) begin miscompares++; $display("[TB] FAIL ignore_frame got oe=%0d len=%0d expected 274/274", oeCycles, obsLen); end
    repeat (30) @(negedge clock);
    vectors++; if (busyB !== 1'b0) begin miscompares++; $display("[TB] FAIL ignore_busy_after got %b expected 0", busyB); end
    vectors++; if (oeCycles !== 274 || doneCount !== 1) begin miscompares++; $display("[TB] FAIL ignore_single_block got oe=%0d done=%0d expected 274/1", oeCycles, doneCount); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (obsCrcR[i] !== refCrc(i) || obsCrcF[i] !== refCrc(8+i)) begin miscompares++; $display("[TB] FAIL ignore_crc_lane%0d got %h/%h expected %h/%h", i, obsCrcR[i], obsCrcF[i], refCrc(i), refCrc(8+i)); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    fillPattern(16'h1234);
    applyStimulus(-1, 0, -1, 1'b0, -1, 1'b1, 1'b0, to);
    vectors++; if (to || doneCount !== 1 || oeCycles !== 274) begin miscompares++; $display("[TB] FAIL b2b_first got to=%b done=%0d oe=%0d expected 0/1/274", to, doneCount, oeCycles); end
    vectors++; if (busyB !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_restart_busy got %b expected 1", busyB); end
    fillPattern(16'hBEEF);
    applyStimulus(-1, 0, -1, 1'b0, -1, 1'b0, 1'b1, to);
    collectBlock();
    vectors++; if (to || doneCount !== 1 || oeCycles !== 274) begin miscompares++; $display("[TB] FAIL b2b_second got to=%b done=%0d oe=%0d expected 0/1/274", to, doneCount, oeCycles); end
    vectors++; if (obsFirst !== 16'h0000 || obsLast !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL b2b_markers got %h/%h expected 0000/ffff", obsFirst, obsLast); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (obsCrcR[i] !== refCrc(i) || obsCrcF[i] !== refCrc(8+i)) begin miscompares++; $display("[TB] FAIL b2b_crc_lane%0d got %h/%h expected %h/%h", i, obsCrcR[i], obsCrcF[i], refCrc(i), refCrc(8+i)); end
    end
  endtask

  task automatic test_random_payload();
    bit to;
    for (int w = 0; w < 256; w++) payload[w] = 16'($urandom);
    applyStimulus(-1, 0, -1, 1'b0, -1, 1'b0, 1'b0, to);
    collectBlock();
    vectors++; if (to || doneCount !== 1 || oeCycles !== 274) begin miscompares++; $display("[TB] FAIL random_frame got to=%b done=%0d oe=%0d expected 0/1/274", to, doneCount, oeCycles); end
    for (int w = 0; w < 256; w++) begin
      vectors++; if (w >= obsWords.size() || obsWords[w] !== payload[w]) begin miscompares++; $display("[TB] FAIL random_word%0d got %h expected %h", w, (w < obsWords.size()) ? obsWords[w] : 16'hxxxx, payload[w]); end
    end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (obsCrcR[i] !== refCrc(i)) begin miscompares++; $display("[TB] FAIL random_crc_rise%0d got %h expected %h", i, obsCrcR[i], refCrc(i)); end
      vectors++; if (obsCrcF[i] !== refCrc(8+i)) begin miscompares++; $display("[TB] FAIL random_crc_fall%0d got %h expected %h", i, obsCrcF[i], refCrc(8+i)); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    oeCycles = 0; stopCycles = 0; holdErr = 0; strayStop = 0; doneCount = 0; doneOeErr = 0;
    lastD1 = 8'hFF;
    lastD2 = 8'hFF;
    resetN = 1'b0;
    startB = 1'b0;
    startS = 1'b0;
    ifB.in_data = 16'h0000;
    ifB.in_valid = 1'b0;
    ifS.in_data = 16'h0000;
    ifS.in_valid = 1'b0;
    @(negedge clock);
    test_reset();
    test_single_word();
    test_zero_payload();
    test_underrun();
    test_reset_mid_block();
    test_start_ignored();
    test_back_to_back();
    test_random_payload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/emmc_ddr8_data_tx.md
# emmc_ddr8_data_tx

Transmit-side data framer for the eMMC host controller in 8-bit DDR (DDR52) write mode. It takes write data as 16-bit words, two bytes per card clock, and builds each data block on the bus: start bit, payload, per-line dual CRC16 and end bit. The block drives the rising-edge and falling-edge byte pair (`d1_wire`, `d2_wire`) straight into the 8-lane DDR output register stage. It also produces the output-enable for the DAT tristate and a clock-stop request for payload underrun.

## Interface

Parameters
- `BLOCK_BYTES`, default 512: payload bytes per block. Must be even, range 2..4096. Payload lasts BLOCK_BYTES/2 cycles.

Ports
- `clock` in 1: controller clock, one card-clock period per cycle.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to send one block. Honoured only in IDLE.
- `in_data` in 16: payload word. `[7:0]` is the rising-edge byte (even byte), `[15:8]` is the falling-edge byte (odd byte). Bit i goes to DAT[i].
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: high in DATA state. A word transfers when `in_valid & in_ready`.
- `d1_wire` out 8: DAT lane values for the rising edge. Registered.
- `d2_wire` out 8: DAT lane values for the falling edge. Registered.
- `dat_oe` out 1: DAT tristate enable. Registered.
- `clk_stop` out 1: asks the clock generator to suppress the card clock this cycle (underrun). Registered.
- `busy` out 1: block in progress (state ≠ IDLE).
- `done` out 1: one-cycle pulse after the end bit.

## Operation

States: IDLE → START → DATA → CRC → END → IDLE.

- **IDLE**
  - Outputs: `d1=d2=8'hFF`, `dat_oe=0`, `clk_stop=0`.
  - `start=1` → START. Clears `cnt` and all 16 CRC registers to 0.
- **START**, one cycle
  - Outputs: `d1=d2=8'h00` (start bit on all lanes, held full cycle), `dat_oe=1`.
  - Next state: DATA.
- **DATA**
  - `in_ready=1`.
  - On a transfer:
    - `d1<=in_data[7:0]`, `d2<=in_data[15:8]`, `clk_stop<=0`, `cnt++`.
    - `crc_r[i]` absorbs `in_data[i]`; `crc_f[i]` absorbs `in_data[8+i]`.
  - Without a transfer: d1/d2 hold, `clk_stop<=1`, CRCs and `cnt` unchanged.
  - Transfer with `cnt==BLOCK_BYTES/2-1` → CRC.
- **CRC**, 16 cycles, counter 0..15
  - Outputs: `d1[i]=crc_r[i][15]`, `d2[i]=crc_f[i][15]`.
  - Both registers shift left by one each cycle, MSB first.
  - After cycle 15 → END.
- **END**, one cycle
  - Outputs: `d1=d2=8'hFF` (end bit), `dat_oe=1`.
  - Next cycle: IDLE with `done=1` and `dat_oe=0`.

CRC arithmetic
- CRC16-CCITT, x^16+x^12+x^5+1, init 0, no final XOR. Serial per bit: `fb = bit ^ crc[15]`; `crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0)`.
- 16 independent registers: 8 rising-edge (`crc_r[i]`) and 8 falling-edge (`crc_f[i]`).

Boundary conditions
- `start` outside IDLE is ignored, with no queueing.
- `in_valid` with `in_ready=0` is not consumed.
- `clk_stop` is asserted only in DATA. It deasserts the cycle a word is accepted.
- `reset_n=0` in any state → next edge: IDLE, and every output at its reset value. Any partial block is abandoned and no `done` is produced.
- Reset values: `d1_wire=d2_wire=8'hFF`, `dat_oe=0`, `clk_stop=0`, `busy=0`, `done=0`, `in_ready=0`.

## Timing

- `start` sampled at edge k → START values on d1/d2 after edge k+1.
- Word accepted at edge m → appears on d1/d2 after edge m (one register stage). The downstream DDR stage adds its own register.
- Block length with no underrun: 1 + BLOCK_BYTES/2 + 16 + 1 cycles with `dat_oe=1`. That is 274 cycles for 512 bytes.
- `done` arrives 1 cycle after END. A new `start` is accepted in that same `done` cycle.
- `busy` is high from the cycle after `start` through END.

## Test plan

- **Single word:** BLOCK_BYTES=2, start, word `16'h0001`.
  - d1/d2 sequence: `00/00`, then `01/00`.
  - CRC: lane 0 rising shows 0x1021 MSB-first (0001 0000 0010 0001); all falling lanes and the other rising lanes are 0.
  - Then `FF/FF`, then `done`.
- **Zero payload:** BLOCK_BYTES=512, 256 zero words, `in_valid` always high.
  - 274 `dat_oe` cycles, all CRC bits 0, `done` exactly once, `clk_stop` never asserted.
- **Underrun:** drop `in_valid` for 3 cycles at word 100.
  - `clk_stop` high for exactly those 3 cycles with d1/d2 held.
  - CRC identical to the uninterrupted run; total `dat_oe` cycles = 277.
- **Reset mid-block:** `reset_n=0` during CRC cycle 5.
  - Next edge: IDLE, `d1=d2=FF`, `dat_oe=0`, no `done`.
  - A following start produces a clean full block.
- **Start ignored when busy:** `start` pulsed during DATA and END.
  - Ignored; one block only.
  - `start` in the `done` cycle begins a new block immediately.
- **Random payload:** 512 random bytes.
  - Per-lane rising and falling CRCs match the reference-model CRC16 of the de-interleaved bitstreams.
